// File: rtl/rename_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : rename_table_if
//  Description : Bundles the control, commit, issue, read-port and ROB-query
//                signals of the rename table. The master modport is the
//                decoder/ROB side; the slave modport is the table itself.
//                Checkpoint signals exist only when REGFILE_CKPT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rename_table_if #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int ROB_WIDTH = 4,
    parameter int NUM_RD    = 2
);
    localparam int REG_W = $clog2(NUM_REGS);

    logic                        rdy_in;
    logic                        clear;
    logic                        commit_valid;
    logic [REG_W-1:0]            commit_reg;
    logic [XLEN-1:0]             commit_val;
    logic [ROB_WIDTH-1:0]        commit_rob;
    logic                        issue_valid;
    logic [REG_W-1:0]            issue_reg;
    logic [ROB_WIDTH-1:0]        issue_rob;
    logic [NUM_RD*REG_W-1:0]     rd_reg;
    logic [NUM_RD*XLEN-1:0]      rd_val;
    logic [NUM_RD-1:0]           rd_dep_v;
    logic [NUM_RD*ROB_WIDTH-1:0] rd_dep;
    logic [NUM_RD*ROB_WIDTH-1:0] rob_q_tag;
    logic [NUM_RD-1:0]           rob_q_rdy;
    logic [NUM_RD*XLEN-1:0]      rob_q_val;
`ifdef REGFILE_CKPT_EN
    logic                        ckpt_save;
    logic                        ckpt_restore;
    logic                        ckpt_valid;
`endif

    modport master (
        output rdy_in, clear,
        output commit_valid, commit_reg, commit_val, commit_rob,
        output issue_valid, issue_reg, issue_rob,
        output rd_reg, rob_q_rdy, rob_q_val,
        input  rd_val, rd_dep_v, rd_dep, rob_q_tag
`ifdef REGFILE_CKPT_EN
        , output ckpt_save, ckpt_restore
        , input  ckpt_valid
`endif
    );

    modport slave (
        input  rdy_in, clear,
        input  commit_valid, commit_reg, commit_val, commit_rob,
        input  issue_valid, issue_reg, issue_rob,
        input  rd_reg, rob_q_rdy, rob_q_val,
        output rd_val, rd_dep_v, rd_dep, rob_q_tag
`ifdef REGFILE_CKPT_EN
        , input  ckpt_save, ckpt_restore
        , output ckpt_valid
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ============================================================================
//  Module      : rename_table
//  Description : Architectural register file plus rename/dependency table.
//                Holds committed values and the in-flight ROB tag per
//                register, serves NUM_RD combinational read ports with commit
//                and ROB bypass. Optional macro REGFILE_CKPT_EN adds a single
//                branch checkpoint of the dependency table.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_table #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int ROB_WIDTH = 4,
    parameter int NUM_RD    = 2
) (
    input  wire logic     clk_in,
    input  wire logic     rst_n_in,
    rename_table_if.slave bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    logic [XLEN-1:0]      r_val  [NUM_REGS];
    logic [ROB_WIDTH-1:0] r_dep  [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;

    // Table after this cycle's commit and issue; next-state after recovery.
    logic [ROB_WIDTH-1:0] w_dep_upd [NUM_REGS];
    logic [NUM_REGS-1:0]  w_busy_upd;
    logic [ROB_WIDTH-1:0] w_dep_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]  w_busy_nxt;

`ifdef REGFILE_CKPT_EN
    logic [ROB_WIDTH-1:0] r_ck_dep [NUM_REGS];
    logic [NUM_REGS-1:0]  r_ck_busy;
    logic                 r_ckpt_valid;
    logic [NUM_REGS-1:0]  w_ck_busy_cmt;

    assign bus.ckpt_valid = r_ckpt_valid;

    // Snapshot busy bits with this cycle's tag-matching commit applied
    always_comb begin
        w_ck_busy_cmt = r_ck_busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.commit_valid && bus.commit_reg == REG_W'(r) && r_ck_dep[r] == bus.commit_rob)
                w_ck_busy_cmt[r] = 1'b0;
        end
    end
`endif

    // Commit clears a rename only when its tag still matches; issue then overrides
    always_comb begin
        w_busy_upd = r_busy;
        w_dep_upd  = r_dep;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.commit_valid && bus.commit_reg == REG_W'(r) && r_dep[r] == bus.commit_rob)
                w_busy_upd[r] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_reg != '0) begin
            w_busy_upd[bus.issue_reg] = 1'b1;
            w_dep_upd[bus.issue_reg]  = bus.issue_rob;
        end
    end

    // Recovery selection: clear beats restore beats normal update
    always_comb begin
        w_busy_nxt = w_busy_upd;
        w_dep_nxt  = w_dep_upd;
        if (bus.clear) begin
            w_busy_nxt = '0;
            for (int r = 0; r < NUM_REGS; r++) w_dep_nxt[r] = '0;
        end
`ifdef REGFILE_CKPT_EN
        else if (bus.ckpt_restore) begin
            if (r_ckpt_valid) begin
                w_busy_nxt = w_ck_busy_cmt;
                w_dep_nxt  = r_ck_dep;
            end else begin
                w_busy_nxt = '0;
                for (int r = 0; r < NUM_REGS; r++) w_dep_nxt[r] = '0;
            end
        end
`endif
    end

    // Committed values: a commit always lands, even during a flush
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NUM_REGS; r++) r_val[r] <= '0;
        end else if (bus.rdy_in && bus.commit_valid && bus.commit_reg != '0) begin
            r_val[bus.commit_reg] <= bus.commit_val;
        end
    end

    // Dependency table register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) r_dep[r] <= '0;
        end else if (bus.rdy_in) begin
            r_busy <= w_busy_nxt;
            r_dep  <= w_dep_nxt;
        end
    end

`ifdef REGFILE_CKPT_EN
    // Checkpoint: save captures the post-update table; held copy tracks commits
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ckpt_valid <= 1'b0;
            r_ck_busy    <= '0;
            for (int r = 0; r < NUM_REGS; r++) r_ck_dep[r] <= '0;
        end else if (bus.rdy_in) begin
            if (bus.clear || bus.ckpt_restore) begin
                r_ckpt_valid <= 1'b0;
            end else if (bus.ckpt_save) begin
                r_ckpt_valid <= 1'b1;
                r_ck_busy    <= w_busy_upd;
                r_ck_dep     <= w_dep_upd;
            end else if (r_ckpt_valid) begin
                r_ck_busy    <= w_ck_busy_cmt;
            end
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_W-1:0]     w_reg;
        logic                 w_busy;
        logic [ROB_WIDTH-1:0] w_tag;
        logic                 w_cmt_hit;
        logic [XLEN-1:0]      w_val;
        logic                 w_dep_v;
        logic [ROB_WIDTH-1:0] w_dep;

        assign w_reg     = bus.rd_reg[p*REG_W +: REG_W];
        assign w_busy    = r_busy[w_reg];
        assign w_tag     = r_dep[w_reg];
        assign w_cmt_hit = bus.commit_valid && (bus.commit_reg == w_reg) && (bus.commit_rob == w_tag);

        // Operand select: zero reg, commit bypass, ROB bypass, pending, committed
        always_comb begin
            w_val   = r_val[w_reg];
            w_dep_v = 1'b0;
            w_dep   = '0;
            if (w_reg == '0) begin
                w_val = '0;
            end else if (w_busy) begin
                w_dep = w_tag;
                if (w_cmt_hit)
                    w_val = bus.commit_val;
                else if (bus.rob_q_rdy[p])
                    w_val = bus.rob_q_val[p*XLEN +: XLEN];
                else
                    w_dep_v = 1'b1;
            end
        end

        assign bus.rd_val[p*XLEN +: XLEN]           = w_val;
        assign bus.rd_dep_v[p]                      = w_dep_v;
        assign bus.rd_dep[p*ROB_WIDTH +: ROB_WIDTH]    = w_dep;
        assign bus.rob_q_tag[p*ROB_WIDTH +: ROB_WIDTH] = w_dep;
    end
endmodule
`default_nettype wire
